// File: rtl/float16_pkg.sv
// Shared definitions for the half-precision arithmetic blocks (divider, multiplier).
// Field widths, special encodings, the divider FSM states and the float16 field layout.
package float16_pkg;

  localparam int EXP_W    = 5;
  localparam int FRAC_W   = 10;
  localparam int EXP_BIAS = 15;

  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] QNAN    = 16'h7E00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_NORM,
    ST_DONE
  } div_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exponent;
    logic [FRAC_W-1:0] frac;
  } float16_t;

endpackage

// File: rtl/float16_classify.sv
// Combinational operand classifier for half-precision values.
// Subnormals report as zero because the arithmetic blocks flush them.
module float16_classify
  import float16_pkg::*;
(
  input  logic [15:0] x,
  output logic        is_neg,
  output logic        is_zero,
  output logic        is_inf,
  output logic        is_nan
);

  float16_t f;

  assign f       = x;
  assign is_neg  = f.sign;
  assign is_zero = (f.exponent == '0);
  assign is_inf  = (f.exponent == '1) && (f.frac == '0);
  assign is_nan  = (f.exponent == '1) && (f.frac != '0);

endmodule

// File: rtl/float_divider.sv
// Sequential half-precision divider: restoring mantissa division, one quotient bit
// per cycle, fixed 14-cycle latency from accepted start to done.
module float_divider
  import float16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] floatA,
  input  logic [15:0] floatB,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient
);

  div_state_t        state_q, state_d;
  float16_t          a_q, a_d;
  float16_t          b_q, b_d;
  logic [11:0]       rem_q, rem_d;
  logic [10:0]       div_q, div_d;
  logic [11:0]       quo_bits_q, quo_bits_d;
  logic [3:0]        count_q, count_d;
  logic signed [6:0] exp_q, exp_d;
  logic [15:0]       quotient_q, quotient_d;

  logic a_neg, a_zero, a_inf, a_nan;
  logic b_neg, b_zero, b_inf, b_nan;

  logic              sign;
  logic [9:0]        mant;
  logic signed [6:0] e_adj;
  logic [15:0]       result;
  logic              rem_ge;

  float16_classify u_class_a (
    .x       (a_q),
    .is_neg  (a_neg),
    .is_zero (a_zero),
    .is_inf  (a_inf),
    .is_nan  (a_nan)
  );

  float16_classify u_class_b (
    .x       (b_q),
    .is_neg  (b_neg),
    .is_zero (b_zero),
    .is_inf  (b_inf),
    .is_nan  (b_nan)
  );

  assign rem_ge = (rem_q >= {1'b0, div_q});

  // Result packing; specials override the numeric path but the divide still runs.
  always_comb begin
    sign   = a_neg ^ b_neg;
    mant   = '0;
    e_adj  = '0;
    result = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      result = QNAN;
    end else if (b_zero || a_inf) begin
      result = {sign, POS_INF[14:0]};
    end else if (a_zero || b_inf) begin
      result = {sign, 15'h0000};
    end else begin
      if (quo_bits_q[11]) begin
        mant  = quo_bits_q[10:1];
        e_adj = exp_q;
      end else begin
        mant  = quo_bits_q[9:0];
        e_adj = exp_q - 7'sd1;
      end
      if (e_adj >= 7'sd31) begin
        result = {sign, POS_INF[14:0]};
      end else if (e_adj <= 7'sd0) begin
        result = {sign, 15'h0000};
      end else begin
        result = {sign, e_adj[4:0], mant};
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    rem_d      = rem_q;
    div_d      = div_q;
    quo_bits_d = quo_bits_q;
    count_d    = count_q;
    exp_d      = exp_q;
    quotient_d = quotient_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d        = floatA;
          b_d        = floatB;
          rem_d      = {2'b01, floatA[9:0]};
          div_d      = {1'b1, floatB[9:0]};
          exp_d      = $signed({2'b00, floatA[14:10]}) - $signed({2'b00, floatB[14:10]})
                       + $signed(7'(EXP_BIAS));
          count_d    = 4'd11;
          quo_bits_d = '0;
          state_d    = ST_DIVIDE;
        end
      end
      ST_DIVIDE: begin
        quo_bits_d[count_q] = rem_ge;
        if (rem_ge) begin
          rem_d = (rem_q - {1'b0, div_q}) << 1;
        end else begin
          rem_d = rem_q << 1;
        end
        count_d = count_q - 4'd1;
        if (count_q == 4'd0) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        quotient_d = result;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      rem_q      <= '0;
      div_q      <= '0;
      quo_bits_q <= '0;
      count_q    <= '0;
      exp_q      <= '0;
      quotient_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      quo_bits_q <= quo_bits_d;
      count_q    <= count_d;
      exp_q      <= exp_d;
      quotient_q <= quotient_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign quotient = quotient_q;

endmodule

// File: tb/tb_float_divider.sv
// Directed-vector bench for float_divider: latency, busy window, specials, range limits,
// ignored starts and mid-operation reset, all against hand-computed quotients.
module tb_float_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] floatA;
  logic [15:0] floatB;
  logic        busy;
  logic        done;
  logic [15:0] quotient;

  int checks   = 0;
  int failures = 0;

  float_divider dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .floatA   (floatA),
    .floatB   (floatB),
    .busy     (busy),
    .done     (done),
    .quotient (quotient)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issues one operation at C0 and follows it to done; checks latency, busy and result.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] exp_q);
    int cyc;
    int busy_low;
    @(posedge clk); #1;
    check_val({tag, "_idle_busy"}, 32'(busy), 32'd0);
    start  = 1'b1;
    floatA = a;
    floatB = b;
    @(posedge clk); #1;
    start    = 1'b0;
    cyc      = 1;
    busy_low = 0;
    while (!done && cyc < 40) begin
      if (!busy) busy_low++;
      @(posedge clk); #1;
      cyc++;
    end
    if (!busy) busy_low++;
    check_val({tag, "_done_cycle"}, 32'(cyc), 32'd14);
    check_val({tag, "_busy_window"}, 32'(busy_low), 32'd0);
    check_val({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
    $display("op %s: %h / %h -> %h (done at C%0d)", tag, a, b, quotient, cyc);
    @(posedge clk); #1;
    check_val({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int done_cnt;
    int first_done;
    int second_done;
    logic [15:0] q_first;
    logic [15:0] q_second;
    logic [15:0] q_mid;

    reset  = 1'b1;
    start  = 1'b0;
    floatA = '0;
    floatB = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_busy", 32'(busy), 32'd0);
    check_val("reset_done", 32'(done), 32'd0);
    check_val("reset_quotient", 32'(quotient), 32'h0);
    reset = 1'b0;

    run_op("one_by_two",   16'h3C00, 16'h4000, 16'h3800);
    run_op("six_by_three", 16'h4600, 16'h4200, 16'h4000);
    run_op("one_by_three", 16'h3C00, 16'h4200, 16'h3555);
    run_op("neg_sign",     16'hC000, 16'h4000, 16'hBC00);
    run_op("div_by_zero",  16'h3C00, 16'h0000, 16'h7C00);
    run_op("zero_by_zero", 16'h0000, 16'h0000, 16'h7E00);
    run_op("zero_num",     16'h0000, 16'h4000, 16'h0000);
    run_op("overflow",     16'h7800, 16'h0400, 16'h7C00);
    run_op("underflow",    16'h0400, 16'h7800, 16'h0000);
    run_op("subnorm_div",  16'h3C00, 16'h0001, 16'h7C00);

    // Starts at C5 and C14 must be ignored; the one at C15 is accepted.
    @(posedge clk); #1;
    start  = 1'b1;
    floatA = 16'h3C00;
    floatB = 16'h4000;
    done_cnt    = 0;
    first_done  = 0;
    second_done = 0;
    q_first     = '0;
    q_second    = '0;
    q_mid       = '0;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_done = c;
          q_first    = quotient;
        end else if (done_cnt == 2) begin
          second_done = c;
          q_second    = quotient;
        end
      end
      if (c == 20) q_mid = quotient;
      start = (c == 5) || (c == 14) || (c == 15);
      if (c == 15) begin
        floatA = 16'h3C00;
        floatB = 16'h4200;
      end else begin
        floatA = 16'h4600;
        floatB = 16'h4200;
      end
    end
    start = 1'b0;
    check_val("ign_done_count", 32'(done_cnt), 32'd2);
    check_val("ign_first_cycle", 32'(first_done), 32'd14);
    check_val("ign_first_q", 32'(q_first), 32'h3800);
    check_val("ign_held_q", 32'(q_mid), 32'h3800);
    check_val("c15_done_cycle", 32'(second_done), 32'd29);
    check_val("c15_quotient", 32'(q_second), 32'h3555);
    $display("ignored-start op: dones=%0d at C%0d,C%0d q=%h,%h", done_cnt, first_done,
             second_done, q_first, q_second);

    // Mid-operation reset asserted at C7 and released at C9.
    repeat (2) @(posedge clk);
    #1;
    start  = 1'b1;
    floatA = 16'h4600;
    floatB = 16'h4200;
    done_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) done_cnt++;
      if (c == 7) begin
        reset = 1'b1;
        #1;
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_quotient", 32'(quotient), 32'h0);
      end
      if (c == 9) reset = 1'b0;
    end
    check_val("rst_no_done", 32'(done_cnt), 32'd0);
    $display("reset op: dones after abort=%0d quotient=%h", done_cnt, quotient);

    run_op("post_reset", 16'h3C00, 16'h4000, 16'h3800);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
